// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, taken-branch flushes and the data-memory
// req/ready handshake for the op held in EX/MEM, with a watchdog on the
// handshake and a saturating count of cycles in which the PC was held.
// Register enables are driven independently of flushes; the datapath gives a
// register's flush priority over its enable.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_num,
  input  logic [4:0]       id_rt_num,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd_num,
  input  logic             branch_taken,
  input  logic             mem_op_valid,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  // Timeout counter only ever holds 0..TIMEOUT_CYCLES-1.
  localparam int            TW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit            WD_ON = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TLAST = WD_ON ? TW'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state, state_next;
  logic [TW-1:0]    tcnt, tcnt_next;
  logic             err_next;
  logic [CNT_W-1:0] stall_next;
  logic             load_use;
  logic             mem_stall;
  logic             abort;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = ex_mem_to_reg && ex_reg_write && (ex_rd_num != 5'd0) &&
               ((id_uses_rs && (id_rs_num == ex_rd_num)) ||
                (id_uses_rt && (id_rt_num == ex_rd_num)));
  end

  // Watchdog fires on the last permitted MEM_WAIT cycle if memory is still busy.
  always_comb begin
    abort = WD_ON && (state == MEM_WAIT) && !dmem_ready && (tcnt == TLAST);
  end

  // Next state and all pipeline controls, in priority order.
  always_comb begin
    state_next   = state;
    tcnt_next    = tcnt;
    err_next     = mem_timeout_err;
    mem_stall    = 1'b0;
    dmem_req     = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          tcnt_next = '0;
          dmem_req  = mem_op_valid;
          if (mem_op_valid && !dmem_ready) begin
            mem_stall  = 1'b1;
            state_next = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            dmem_req   = 1'b1;
            state_next = RUN;
            tcnt_next  = '0;
          end else if (abort) begin
            // Access is dropped; EX/MEM moves on and MEM/WB gets a bubble.
            err_next     = 1'b1;
            mem_wb_flush = 1'b1;
            state_next   = RUN;
            tcnt_next    = '0;
          end else begin
            dmem_req  = 1'b1;
            mem_stall = 1'b1;
            if (WD_ON) tcnt_next = tcnt + TW'(1);
          end
        end
        default: state_next = RUN;
      endcase

      if (mem_stall) begin
        // Hold everything up to EX/MEM; the held EX instr re-raises branch/load-use later.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // One bubble suffices: the load leaves EX at the next edge.
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Saturating count of held-PC cycles.
  always_comb begin
    stall_next = stall_cycles;
    if (!pc_en && (stall_cycles != {CNT_W{1'b1}})) stall_next = stall_cycles + CNT_W'(1);
  end

  // State, watchdog, sticky error and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      tcnt            <= '0;
      mem_timeout_err <= 1'b0;
      stall_cycles    <= '0;
    end else begin
      state           <= state_next;
      tcnt            <= tcnt_next;
      mem_timeout_err <= err_next;
      stall_cycles    <= stall_next;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: sequential vector table through a scoreboard
// queue, plus hand-written reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs_num, id_rt_num, ex_rd_num;
  logic          id_uses_rs, id_uses_rt, ex_mem_to_reg, ex_reg_write;
  logic          branch_taken, mem_op_valid, dmem_ready;
  logic          dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs_num(id_rs_num), .id_rt_num(id_rt_num),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_rd_num(ex_rd_num),
    .branch_taken(branch_taken), .mem_op_valid(mem_op_valid), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // ctl = {req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}
  localparam logic [9:0] C_NORM  = 10'b0_11111_0000;
  localparam logic [9:0] C_LU    = 10'b0_00111_0100;
  localparam logic [9:0] C_BR    = 10'b0_11111_1100;
  localparam logic [9:0] C_BRREQ = 10'b1_11111_1100;
  localparam logic [9:0] C_MST   = 10'b1_00001_0001;
  localparam logic [9:0] C_ZW    = 10'b1_11111_0000;
  localparam logic [9:0] C_ABT   = 10'b0_11111_0001;
  localparam logic [9:0] C_RST   = 10'b0_00000_1111;

  typedef struct {
    logic [4:0] rs, rt, rd;
    logic       urs, urt, ld, rw, br, mv, rdy;
    logic [9:0] ctl;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_stall = 0;

  function automatic vec_t mk(input logic [4:0] rs, rt, rd,
                              input logic urs, urt, ld, rw, br, mv, rdy,
                              input logic [9:0] ctl, input logic err);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.urs = urs; v.urt = urt; v.ld = ld; v.rw = rw;
    v.br = br; v.mv = mv; v.rdy = rdy; v.ctl = ctl; v.err = err;
    return v;
  endfunction

  function automatic logic [9:0] ctl_now();
    return {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs_num = v.rs; id_rt_num = v.rt; ex_rd_num = v.rd;
    id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_mem_to_reg = v.ld; ex_reg_write = v.rw;
    branch_taken = v.br; mem_op_valid = v.mv; dmem_ready = v.rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    // rs rt rd urs urt ld rw br mv rdy ctl err
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0));  // idle
    tbl.push_back(mk(5, 0, 5, 1, 0, 1, 1, 0, 0, 0, C_LU,   0));  // load-use on rs
    tbl.push_back(mk(5, 0, 6, 1, 0, 0, 0, 0, 0, 0, C_NORM, 0));  // load left EX
    tbl.push_back(mk(1, 7, 7, 1, 1, 1, 1, 0, 0, 0, C_LU,   0));  // load-use on rt
    tbl.push_back(mk(0, 3, 0, 1, 0, 1, 1, 0, 0, 0, C_NORM, 0));  // rd=r0 never stalls
    tbl.push_back(mk(5, 0, 5, 0, 0, 1, 1, 0, 0, 0, C_NORM, 0));  // rs not used
    tbl.push_back(mk(5, 0, 5, 1, 0, 0, 1, 0, 0, 0, C_NORM, 0));  // not a load
    tbl.push_back(mk(5, 0, 5, 1, 0, 1, 0, 0, 0, 0, C_NORM, 0));  // no reg write
    tbl.push_back(mk(5, 0, 5, 1, 0, 1, 1, 1, 0, 0, C_BR,   0));  // branch beats load-use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ZW,   0));  // zero-wait access
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MST,  0));  // stall entry, branch ignored
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_MST,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MST,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_BRREQ, 0)); // ready: acts as RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0));  // back in RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MST,  0));  // timeout run
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MST,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MST,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MST,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_ABT,  0));  // 4th MEM_WAIT cycle aborts
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1));  // RUN, error sticky
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ZW,   1));
    for (int k = 0; k < 8; k++)                                  // drive counter to saturation
      tbl.push_back(mk(9, 0, 9, 1, 0, 1, 1, 0, 0, 0, C_LU, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 1));

    // Reset state
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0));
    rst = 1'b1;
    #1;
    chk("reset_ctl", 32'(ctl_now()), 32'(C_RST));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    chk("reset_err", 32'(mem_timeout_err), 32'd0);
    rst = 1'b0;
    exp_stall = 0;

    // Table through scoreboard
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_ctl", i), 32'(ctl_now()), 32'(e.ctl));
      chk($sformatf("v%0d_err", i), 32'(mem_timeout_err), 32'(e.err));
      chk($sformatf("v%0d_stall", i), 32'(stall_cycles), 32'(exp_stall));
      $display("vec %0d: ctl=%b err=%b stall=%0d", i, ctl_now(), mem_timeout_err, stall_cycles);
      if (e.ctl[8] == 1'b0 && exp_stall < (1 << CW) - 1) exp_stall++;
    end

    // Reset asserted mid-MEM_WAIT abandons the access
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MST, 1));
    @(posedge clk); #1;                 // now in MEM_WAIT
    chk("mw_before_rst", 32'(ctl_now()), 32'(C_MST));
    #2;
    rst = 1'b1;
    #1;
    chk("mw_rst_ctl", 32'(ctl_now()), 32'(C_RST));
    chk("mw_rst_stall", 32'(stall_cycles), 32'd0);
    chk("mw_rst_err", 32'(mem_timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM, 0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_run", 32'(ctl_now()), 32'(C_NORM));
    chk("post_rst_stall", 32'(stall_cycles), 32'd0);
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_ZW, 0));
    @(negedge clk);
    chk("post_rst_zw", 32'(ctl_now()), 32'(C_ZW));
    $display("reset-in-MEM_WAIT sequence: ctl=%b stall=%0d", ctl_now(), stall_cycles);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
